dsi_lp_esc_rx: RTL
==================

Name: dsi_lp_esc_rx

Overview:
- Low-power escape-mode receiver for one DSI data lane, for the reverse (peripheral-to-host) direction after bus turnaround.
- Samples LP_p/LP_n pad inputs, synchronizes and glitch-filters them, then detects the escape entry sequence LP-11→10→00→01→00.
- Decodes the 8-bit spaced-one-hot entry command. For LPDT it delivers received bytes; it also reports other commands and exit and protocol errors.
- Bit order is MSB-first, matching our lane transmitter: the first received bit lands in bit 7.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per LP line.
- FILTER_CYCLES, 3, number of consecutive identical synchronized samples required before the filtered line state changes (1..15).

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- lines_enable  in  1  receiver enable; 0 forces DISABLED
- LP_p_input  in  1  asynchronous LP_p pad input
- LP_n_input  in  1  asynchronous LP_n pad input
- rx_data  out  8  last received LPDT byte; held until the next byte
- rx_data_valid  out  1  one-cycle pulse per received byte
- rx_end  out  1  one-cycle pulse when an LPDT session terminates
- rx_active  out  1  high from escape request through end of the session
- cmd_code  out  8  last non-LPDT entry command; held
- cmd_valid  out  1  one-cycle pulse with a new cmd_code
- err_sync  out  1  one-cycle pulse: mark followed by the opposite mark with no LP-00 space
- err_esc  out  1  one-cycle pulse: malformed escape entry, or stop before the command completed
- err_partial  out  1  one-cycle pulse: LPDT stopped with 1..7 bits pending

Behaviour:
- Reset:
  - All outputs 0; rx_data and cmd_code = 0x00.
  - Filtered line state = LP-11; FSM in DISABLED.
- Filter:
  - Filtered state {p,n} updates once the synchronized value has differed from it for FILTER_CYCLES consecutive cycles.
  - Each update emits an internal change pulse.
  - Pin-to-filtered latency is SYNC_STAGES+FILTER_CYCLES cycles. Shorter glitches are ignored.
- FSM acts only on change pulses, except DISABLED and WAIT_STOP, which act on the filtered level.
- State transitions:
  - DISABLED: when lines_enable=1 → WAIT_STOP.
  - WAIT_STOP: filtered LP-11 → STOP.
  - STOP:
    - LP-10 → ESC_RQST.
    - LP-01 (HS request, not handled here) → WAIT_STOP, no error.
    - LP-00 → WAIT_STOP plus err_esc.
  - ESC_RQST:
    - LP-00 → ESC_GO.
    - LP-11 → STOP, no error.
    - LP-01 → WAIT_STOP plus err_esc.
  - ESC_GO:
    - LP-01 → ESC_CONF.
    - LP-10 (turnaround) → WAIT_STOP, no error.
    - LP-11 → STOP plus err_esc.
  - ESC_CONF:
    - LP-00 → CMD, with bit_cnt=0 and the shift register cleared.
    - LP-11 → STOP plus err_esc.
    - LP-10 → WAIT_STOP plus err_esc.
- Bit decoding in CMD and DATA:
  - A mark is LP-10 (bit value 1) or LP-01 (bit value 0). It is shifted in at the mark and sets mark_pending.
  - The following LP-00 is the space: it clears mark_pending and increments bit_cnt (3-bit, wraps 7→0).
  - A mark followed by the opposite mark → err_sync, then WAIT_STOP.
- CMD, on the space completing bit 8:
  - Shift value 0xE1 → DATA.
  - Any other value → load cmd_code, pulse cmd_valid, then WAIT_STOP (the lane stays in ULPS or similar until LP-11).
  - LP-11 in CMD → STOP plus err_esc.
- DATA:
  - On the 8th space, rx_data ← shift value and rx_data_valid pulses 1 cycle after the change pulse. Back-to-back bytes are supported.
  - LP-11 → STOP with an rx_end pulse.
  - If bit_cnt≠0, err_partial pulses in the same cycle as rx_end. A pending mark-one LP-10 with bit_cnt=0 is the normal exit, with no error.
  - err_sync in DATA also pulses rx_end.
- rx_active = state ∈ {ESC_RQST, ESC_GO, ESC_CONF, CMD, DATA}, registered.
- lines_enable=0 in any state:
  - Next cycle → DISABLED; partial data is discarded.
  - No rx_end or errors; all pulses forced 0.
  - Filter keeps running.
- Asynchronous reset mid-operation returns everything to the reset values immediately.
- No backpressure: the consumer must accept rx_data_valid every cycle. LP bit time is at least 2×(SYNC_STAGES+FILTER_CYCLES) cycles.

Decomposition:
- Package dsi_lp_pkg:
  - lp_state_t enum: LP00, LP01, LP10, LP11.
  - Escape command constants: ESC_CMD_LPDT=0xE1, ESC_CMD_ULPS=0x1E, ESC_CMD_RESET_TRIG=0x62.
  - Receiver FSM state enum.
- Sub-module dsi_lp_line_filter:
  - Contains the synchronizers and the stability counter for both lines.
  - Outputs lp_state[1:0] and lp_change.
  - Parameters SYNC_STAGES and FILTER_CYCLES.

Test Plan:
- Hold each line state 8 cycles: LP-11, escape entry, command 0xE1, bytes 0xA5 then 0x3C, mark-one LP-10, LP-11 → rx_data_valid twice with 0xA5 then 0x3C, one rx_end, no error pulses, rx_active low after the stop.
- Escape entry plus command 0x1E, then LP-00 hold, then LP-11 → cmd_valid once with cmd_code=0x1E, no rx_data_valid, no rx_end, FSM back in STOP.
- 2-cycle LP-00 glitch during LP-11, and 1-cycle p/n glitches inside bit marks during an LPDT byte 0x81 → glitches ignored, byte 0x81 received once.
- LPDT byte 0x55, then 5 bits of a second byte, then LP-11 → one rx_data_valid (0x55), rx_end and err_partial in the same cycle.
- In DATA, LP-10 directly followed by LP-01 → err_sync plus rx_end, then WAIT_STOP. A following full sequence with byte 0xC3 decodes correctly.
- lines_enable dropped mid-byte → no pulses, DISABLED. Re-enable plus a clean sequence with 0x12 → received correctly. rst_n asserted mid-byte → all outputs 0 asynchronously.

Source files
------------

// File: rtl/dsi_lp_pkg.sv
// Shared types and escape command codes for the DSI low-power escape receiver.
package dsi_lp_pkg;

  // Encoded as {LP_p, LP_n}
  typedef enum logic [1:0] {
    LP00 = 2'b00,
    LP01 = 2'b01,
    LP10 = 2'b10,
    LP11 = 2'b11
  } lp_state_t;

  localparam logic [7:0] ESC_CMD_LPDT       = 8'hE1;
  localparam logic [7:0] ESC_CMD_ULPS       = 8'h1E;
  localparam logic [7:0] ESC_CMD_RESET_TRIG = 8'h62;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_WAIT_STOP = 3'd1,
    ST_STOP      = 3'd2,
    ST_ESC_RQST  = 3'd3,
    ST_ESC_GO    = 3'd4,
    ST_ESC_CONF  = 3'd5,
    ST_CMD       = 3'd6,
    ST_DATA      = 3'd7
  } rx_state_t;

endpackage

// File: rtl/dsi_lp_line_filter.sv
// Synchronizes LP_p/LP_n and only accepts a new line state after it has been
// stable for FILTER_CYCLES cycles; pulses o_lp_change on each accepted update.
module dsi_lp_line_filter
  import dsi_lp_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       i_p,
  input  logic       i_n,
  output logic [1:0] o_lp_state,
  output logic       o_lp_change
);

  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync_p, r_sync_n;
  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic                   r_change;
  logic [1:0]             w_sync;

  assign w_sync = {r_sync_p[SYNC_STAGES-1], r_sync_n[SYNC_STAGES-1]};

  // Lines idle high, so the chain resets to LP-11 to avoid a false edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p <= '1;
      r_sync_n <= '1;
    end else begin
      r_sync_p[0] <= i_p;
      r_sync_n[0] <= i_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync_p[i] <= r_sync_p[i-1];
        r_sync_n[i] <= r_sync_n[i-1];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LP11;
      r_cnt    <= '0;
      r_change <= 1'b0;
    end else begin
      r_change <= 1'b0;
      if (w_sync == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_state  <= w_sync;
        r_change <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_lp_state  = r_state;
  assign o_lp_change = r_change;

endmodule

// File: rtl/dsi_lp_esc_rx.sv
// LP escape-mode receiver for one reverse-direction DSI data lane: entry
// detection, spaced-one-hot command decode, LPDT byte delivery and errors.
module dsi_lp_esc_rx
  import dsi_lp_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       lines_enable,
  input  logic       LP_p_input,
  input  logic       LP_n_input,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_end,
  output logic       rx_active,
  output logic [7:0] cmd_code,
  output logic       cmd_valid,
  output logic       err_sync,
  output logic       err_esc,
  output logic       err_partial
);

  logic [1:0] w_lp_raw;
  logic       w_chg;
  lp_state_t  w_lp;

  dsi_lp_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .i_p        (LP_p_input),
    .i_n        (LP_n_input),
    .o_lp_state (w_lp_raw),
    .o_lp_change(w_chg)
  );

  assign w_lp = lp_state_t'(w_lp_raw);

  rx_state_t  r_state, w_nxt;
  logic [7:0] r_shift, w_shift;
  logic [2:0] r_cnt, w_cnt;
  logic       r_pend, w_pend;
  logic       r_mbit, w_mbit;
  logic [7:0] r_rx_data, r_cmd_code;
  logic       r_dv, r_end, r_cv, r_esync, r_eesc, r_epart, r_active;
  logic       w_dv, w_end, w_cv, w_esync, w_eesc, w_epart;
  logic       w_mark, w_bit;

  assign w_mark = (w_lp == LP10) || (w_lp == LP01);
  assign w_bit  = (w_lp == LP10);

  always_comb begin
    w_nxt   = r_state;
    w_shift = r_shift;
    w_cnt   = r_cnt;
    w_pend  = r_pend;
    w_mbit  = r_mbit;
    w_dv    = 1'b0;
    w_end   = 1'b0;
    w_cv    = 1'b0;
    w_esync = 1'b0;
    w_eesc  = 1'b0;
    w_epart = 1'b0;
    if (!lines_enable) begin
      w_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED:  w_nxt = ST_WAIT_STOP;
        ST_WAIT_STOP: if (w_lp == LP11) w_nxt = ST_STOP;
        ST_STOP: if (w_chg) begin
          case (w_lp)
            LP10:    w_nxt = ST_ESC_RQST;
            LP01:    w_nxt = ST_WAIT_STOP;
            LP00:    begin w_nxt = ST_WAIT_STOP; w_eesc = 1'b1; end
            default: ;
          endcase
        end
        ST_ESC_RQST: if (w_chg) begin
          case (w_lp)
            LP00:    w_nxt = ST_ESC_GO;
            LP11:    w_nxt = ST_STOP;
            LP01:    begin w_nxt = ST_WAIT_STOP; w_eesc = 1'b1; end
            default: ;
          endcase
        end
        ST_ESC_GO: if (w_chg) begin
          case (w_lp)
            LP01:    w_nxt = ST_ESC_CONF;
            LP10:    w_nxt = ST_WAIT_STOP;
            LP11:    begin w_nxt = ST_STOP; w_eesc = 1'b1; end
            default: ;
          endcase
        end
        ST_ESC_CONF: if (w_chg) begin
          case (w_lp)
            LP00: begin
              w_nxt   = ST_CMD;
              w_cnt   = '0;
              w_shift = '0;
              w_pend  = 1'b0;
            end
            LP11:    begin w_nxt = ST_STOP; w_eesc = 1'b1; end
            LP10:    begin w_nxt = ST_WAIT_STOP; w_eesc = 1'b1; end
            default: ;
          endcase
        end
        ST_CMD, ST_DATA: if (w_chg) begin
          if (w_lp == LP11) begin
            w_nxt = ST_STOP;
            if (r_state == ST_CMD) begin
              w_eesc = 1'b1;
            end else begin
              w_end   = 1'b1;
              w_epart = (r_cnt != 3'd0);
            end
          end else if (w_mark) begin
            if (r_pend && (r_mbit != w_bit)) begin
              w_esync = 1'b1;
              w_end   = (r_state == ST_DATA);
              w_nxt   = ST_WAIT_STOP;
            end else begin
              w_shift = {r_shift[6:0], w_bit};
              w_pend  = 1'b1;
              w_mbit  = w_bit;
            end
          end else if (r_pend) begin
            // LP-00 space commits the pending bit
            w_pend = 1'b0;
            w_cnt  = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_state == ST_DATA) begin
                w_dv = 1'b1;
              end else if (r_shift == ESC_CMD_LPDT) begin
                w_nxt = ST_DATA;
              end else begin
                w_cv  = 1'b1;
                w_nxt = ST_WAIT_STOP;
              end
            end
          end
        end
        default: w_nxt = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_DISABLED;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_mbit     <= 1'b0;
      r_rx_data  <= '0;
      r_cmd_code <= '0;
      r_dv       <= 1'b0;
      r_end      <= 1'b0;
      r_cv       <= 1'b0;
      r_esync    <= 1'b0;
      r_eesc     <= 1'b0;
      r_epart    <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_shift  <= w_shift;
      r_cnt    <= w_cnt;
      r_pend   <= w_pend;
      r_mbit   <= w_mbit;
      r_dv     <= w_dv;
      r_end    <= w_end;
      r_cv     <= w_cv;
      r_esync  <= w_esync;
      r_eesc   <= w_eesc;
      r_epart  <= w_epart;
      r_active <= (w_nxt == ST_ESC_RQST) || (w_nxt == ST_ESC_GO) ||
                  (w_nxt == ST_ESC_CONF) || (w_nxt == ST_CMD) || (w_nxt == ST_DATA);
      if (w_dv) r_rx_data  <= r_shift;
      if (w_cv) r_cmd_code <= r_shift;
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_dv;
  assign rx_end        = r_end;
  assign rx_active     = r_active;
  assign cmd_code      = r_cmd_code;
  assign cmd_valid     = r_cv;
  assign err_sync      = r_esync;
  assign err_esc       = r_eesc;
  assign err_partial   = r_epart;

endmodule
